spm_dual_port: RTL and testbench

- Scratchpad-memory (SPM) responder: the target end of the SPM interface driven by the MEM stage bus interface, plus a read-only instruction-fetch port.
- Provides a fixed one-cycle read latency on both ports and write-first forwarding between the ports.
- Runs a post-reset clear sweep and signals readiness so the top level can stall the pipeline until memory is zeroed.

---
 rtl/spm_dual_port_pkg.sv | 20 ++
 rtl/spm_dual_port_ram.sv | 42 ++++
 rtl/spm_dual_port.sv | 127 ++++++++++++
 tb/tb_spm_dual_port.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/spm_dual_port_pkg.sv
// Shared encodings and sizing for the scratchpad memory responder.
package spm_dual_port_pkg;

    localparam int SPM_DEPTH   = 4096;
    localparam int SPM_ADDR_W  = 12;
    localparam int WORD_ADDR_W = 30;
    localparam int WORD_DATA_W = 32;

    // Bus direction and active-low strobe levels used by the MEM stage bus.
    localparam logic READ     = 1'b1;
    localparam logic WRITE    = 1'b0;
    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

    typedef enum logic {
        SPM_STATE_INIT = 1'b0,
        SPM_STATE_RUN  = 1'b1
    } spm_state_e;

endpackage

// File: rtl/spm_dual_port_ram.sv
// Plain dual-port synchronous array: port A read-only, port B read/write, no reset.
// Read data registers hold their value when the port is not enabled.
module spm_ram #(
    parameter int DEPTH  = 4096,
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              i_a_en,
    input  logic [ADDR_W-1:0] i_a_addr,
    output logic [DATA_W-1:0] o_a_rd_data,
    input  logic              i_b_en,
    input  logic              i_b_we,
    input  logic [ADDR_W-1:0] i_b_addr,
    input  logic [DATA_W-1:0] i_b_wr_data,
    output logic [DATA_W-1:0] o_b_rd_data
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_a_q;
    logic [DATA_W-1:0] r_b_q;

    always_ff @(posedge clk) begin
        if (i_a_en) begin
            r_a_q <= r_mem[i_a_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (i_b_en) begin
            if (i_b_we) begin
                r_mem[i_b_addr] <= i_b_wr_data;
            end else begin
                r_b_q <= r_mem[i_b_addr];
            end
        end
    end

    assign o_a_rd_data = r_a_q;
    assign o_b_rd_data = r_b_q;

endmodule

// File: rtl/spm_dual_port.sv
// SPM responder: MEM read/write port plus IF read port, one-cycle read latency, write-first forwarding.
// No backpressure: strobes are accepted every cycle once spm_ready is high; ignored during the clear sweep.
module spm_dual_port
    import spm_dual_port_pkg::*;
#(
    parameter int DEPTH  = SPM_DEPTH,
    parameter int ADDR_W = SPM_ADDR_W,
    parameter int DATA_W = WORD_DATA_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [WORD_ADDR_W-1:0] if_spm_addr,
    input  logic                   if_spm_as_,
    output logic [DATA_W-1:0]      if_spm_rd_data,
    input  logic [WORD_ADDR_W-1:0] spm_addr,
    input  logic                   spm_as_,
    input  logic                   spm_rw,
    input  logic [DATA_W-1:0]      spm_wr_data,
    output logic [DATA_W-1:0]      spm_rd_data,
    output logic                   spm_ready
);

    spm_state_e        r_state;
    logic [ADDR_W-1:0] r_clr_cnt;
    logic              r_ready;
    logic              r_mem_vld;
    logic              r_mem_src_wr;
    logic [DATA_W-1:0] r_mem_wdat;
    logic              r_if_vld;
    logic              r_if_src_fwd;
    logic [DATA_W-1:0] r_if_fdat;

    logic              w_run;
    logic              w_mem_acc;
    logic              w_mem_wr;
    logic              w_if_acc;
    logic              w_if_fwd;
    logic [ADDR_W-1:0] w_mem_idx;
    logic [ADDR_W-1:0] w_if_idx;
    logic              w_b_en;
    logic              w_b_we;
    logic [ADDR_W-1:0] w_b_addr;
    logic [DATA_W-1:0] w_b_wr_data;
    logic [DATA_W-1:0] w_a_q;
    logic [DATA_W-1:0] w_b_q;
    logic              w_unused;

    // Upper word-address bits are dropped so addresses alias modulo DEPTH.
    assign w_mem_idx = spm_addr[ADDR_W-1:0];
    assign w_if_idx  = if_spm_addr[ADDR_W-1:0];
    assign w_unused  = ^{spm_addr[WORD_ADDR_W-1:ADDR_W], if_spm_addr[WORD_ADDR_W-1:ADDR_W]};

    assign w_run     = (r_state == SPM_STATE_RUN);
    assign w_mem_acc = w_run && (spm_as_ == ENABLE_);
    assign w_mem_wr  = w_mem_acc && (spm_rw == WRITE);
    assign w_if_acc  = w_run && (if_spm_as_ == ENABLE_);
    assign w_if_fwd  = w_if_acc && w_mem_wr && (w_if_idx == w_mem_idx);

    // Port B is owned by the clear sweep until the FSM reaches RUN.
    assign w_b_en      = !w_run || w_mem_acc;
    assign w_b_we      = !w_run || w_mem_wr;
    assign w_b_addr    = w_run ? w_mem_idx : r_clr_cnt;
    assign w_b_wr_data = w_run ? spm_wr_data : '0;

    spm_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk         (clk),
        .i_a_en      (w_if_acc),
        .i_a_addr    (w_if_idx),
        .o_a_rd_data (w_a_q),
        .i_b_en      (w_b_en),
        .i_b_we      (w_b_we),
        .i_b_addr    (w_b_addr),
        .i_b_wr_data (w_b_wr_data),
        .o_b_rd_data (w_b_q)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= SPM_STATE_INIT;
            r_clr_cnt    <= '0;
            r_ready      <= 1'b0;
            r_mem_vld    <= 1'b0;
            r_mem_src_wr <= 1'b0;
            r_mem_wdat   <= '0;
            r_if_vld     <= 1'b0;
            r_if_src_fwd <= 1'b0;
            r_if_fdat    <= '0;
        end else begin
            case (r_state)
                SPM_STATE_INIT: begin
                    r_clr_cnt <= r_clr_cnt + 1'b1;
                    if (r_clr_cnt == ADDR_W'(DEPTH - 1)) begin
                        r_state <= SPM_STATE_RUN;
                        r_ready <= 1'b1;
                    end
                end
                default: begin
                    r_ready <= 1'b1;
                end
            endcase
            if (w_mem_acc) begin
                r_mem_vld    <= 1'b1;
                r_mem_src_wr <= w_mem_wr;
                if (w_mem_wr) begin
                    r_mem_wdat <= spm_wr_data;
                end
            end
            if (w_if_acc) begin
                r_if_vld     <= 1'b1;
                r_if_src_fwd <= w_if_fwd;
                if (w_if_fwd) begin
                    r_if_fdat <= spm_wr_data;
                end
            end
        end
    end

    // RAM read registers have no reset; the valid flags force zero until a real access lands.
    assign spm_rd_data    = !r_mem_vld ? '0 : (r_mem_src_wr ? r_mem_wdat : w_b_q);
    assign if_spm_rd_data = !r_if_vld  ? '0 : (r_if_src_fwd ? r_if_fdat  : w_a_q);
    assign spm_ready      = r_ready;

endmodule

// File: tb/tb_spm_dual_port.sv
// Directed plus random bench for spm_dual_port against an array-based reference model.
module tb_spm_dual_port;

    localparam int DEPTH = 4096;

    logic        clk;
    logic        reset;
    logic [29:0] if_spm_addr;
    logic        if_spm_as_;
    logic [31:0] if_spm_rd_data;
    logic [29:0] spm_addr;
    logic        spm_as_;
    logic        spm_rw;
    logic [31:0] spm_wr_data;
    logic [31:0] spm_rd_data;
    logic        spm_ready;

    int errors = 0;
    int checks = 0;

    logic [31:0] m_mem [DEPTH];
    bit          m_run;
    int          m_cnt;
    logic [31:0] e_mem;
    logic [31:0] e_if;

    spm_dual_port dut (
        .clk            (clk),
        .reset          (reset),
        .if_spm_addr    (if_spm_addr),
        .if_spm_as_     (if_spm_as_),
        .if_spm_rd_data (if_spm_rd_data),
        .spm_addr       (spm_addr),
        .spm_as_        (spm_as_),
        .spm_rw         (spm_rw),
        .spm_wr_data    (spm_wr_data),
        .spm_rd_data    (spm_rd_data),
        .spm_ready      (spm_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;
        m_run = 0;
        m_cnt = 0;
        e_mem = 32'h0;
        e_if  = 32'h0;
    endtask

    // Behaviour of one rising edge, computed from the inputs currently applied.
    task automatic model_edge();
        int  mi;
        int  fi;
        bit  wr;
        if (!m_run) begin
            m_cnt++;
            if (m_cnt == DEPTH) m_run = 1;
        end else begin
            mi = int'(spm_addr) % DEPTH;
            fi = int'(if_spm_addr) % DEPTH;
            wr = (spm_as_ == 1'b0) && (spm_rw == 1'b0);
            if (!if_spm_as_) e_if = (wr && fi == mi) ? spm_wr_data : m_mem[fi];
            if (!spm_as_) e_mem = spm_rw ? m_mem[mi] : spm_wr_data;
            if (wr) m_mem[mi] = spm_wr_data;
        end
    endtask

    task automatic cyc();
        model_edge();
        @(posedge clk);
        #1;
        chk("spm_rd_data", spm_rd_data, e_mem);
        chk("if_spm_rd_data", if_spm_rd_data, e_if);
        chk("spm_ready", {31'h0, spm_ready}, {31'h0, m_run});
    endtask

    task automatic idle();
        spm_as_ = 1'b1;
        if_spm_as_ = 1'b1;
        spm_rw = 1'b1;
    endtask

    task automatic mem_wr(input int a, input logic [31:0] d);
        spm_addr = 30'(a);
        spm_as_ = 1'b0;
        spm_rw = 1'b0;
        spm_wr_data = d;
    endtask

    task automatic mem_rd(input int a);
        spm_addr = 30'(a);
        spm_as_ = 1'b0;
        spm_rw = 1'b1;
    endtask

    task automatic if_rd(input int a);
        if_spm_addr = 30'(a);
        if_spm_as_ = 1'b0;
    endtask

    task automatic sweep();
        for (int i = 0; i < DEPTH; i++) begin
            if (i == DEPTH - 1) chk("ready_low_before_last_edge", {31'h0, spm_ready}, 32'h0);
            cyc();
        end
        chk("ready_high_after_sweep", {31'h0, spm_ready}, 32'h1);
    endtask

    initial begin
        reset = 1'b1;
        spm_addr = '0;
        if_spm_addr = '0;
        spm_wr_data = '0;
        idle();
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("reset_spm_rd_data", spm_rd_data, 32'h0);
        chk("reset_if_rd_data", if_spm_rd_data, 32'h0);
        chk("reset_ready", {31'h0, spm_ready}, 32'h0);
        reset = 1'b0;

        // Sweep with a write strobe at cycle 2 that must be ignored.
        for (int i = 0; i < DEPTH; i++) begin
            if (i == 2) mem_wr(7, 32'hFFFF_FFFF);
            if (i == 3) idle();
            if (i == DEPTH - 1) chk("ready_low_before_last_edge", {31'h0, spm_ready}, 32'h0);
            cyc();
        end
        chk("ready_high_at_edge_depth", {31'h0, spm_ready}, 32'h1);

        mem_rd(0); if_rd(0); cyc();
        chk("rd_idx0_mem", spm_rd_data, 32'h0);
        chk("rd_idx0_if", if_spm_rd_data, 32'h0);
        mem_rd(5); if_rd(5); cyc();
        chk("rd_idx5_mem", spm_rd_data, 32'h0);
        mem_rd(DEPTH - 1); if_rd(DEPTH - 1); cyc();
        chk("rd_last_if", if_spm_rd_data, 32'h0);
        mem_rd(7); cyc();
        chk("init_write_ignored", spm_rd_data, 32'h0);

        mem_wr(16, 32'hDEAD_BEEF); if_spm_as_ = 1'b1; cyc();
        chk("write_first_mem", spm_rd_data, 32'hDEAD_BEEF);
        mem_rd(16); cyc();
        chk("read_back_mem", spm_rd_data, 32'hDEAD_BEEF);
        idle(); cyc();
        chk("hold_mem", spm_rd_data, 32'hDEAD_BEEF);

        mem_rd(32); if_rd(32); cyc();
        chk("prior_value_mem", spm_rd_data, 32'h0);
        mem_wr(32, 32'h1234_5678); if_rd(32); cyc();
        chk("collision_fwd_if", if_spm_rd_data, 32'h1234_5678);
        mem_wr(32, 32'h0BAD_F00D); if_spm_as_ = 1'b1; cyc();
        chk("if_hold_after_fwd", if_spm_rd_data, 32'h1234_5678);

        mem_wr(DEPTH + 3, 32'hA5A5_A5A5); if_spm_as_ = 1'b1; cyc();
        spm_as_ = 1'b1; if_rd(3); cyc();
        chk("alias_if", if_spm_rd_data, 32'hA5A5_A5A5);

        for (int i = 0; i < 400; i++) begin
            spm_addr    = 30'($urandom_range(0, 3) * DEPTH + $urandom_range(0, 15));
            if_spm_addr = 30'($urandom_range(0, 3) * DEPTH + $urandom_range(0, 15));
            spm_as_     = 1'($urandom_range(0, 3) == 0);
            if_spm_as_  = 1'($urandom_range(0, 3) == 0);
            spm_rw      = 1'($urandom);
            spm_wr_data = $urandom;
            cyc();
        end

        // Reset mid-RUN with a write in flight.
        idle();
        mem_wr(1, 32'h0000_0055); cyc();
        mem_wr(2, 32'h0000_0077); if_rd(1);
        #2;
        reset = 1'b1;
        #1;
        chk("midreset_spm_rd_data", spm_rd_data, 32'h0);
        chk("midreset_if_rd_data", if_spm_rd_data, 32'h0);
        chk("midreset_ready", {31'h0, spm_ready}, 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle();
        sweep();
        mem_rd(1); if_rd(2); cyc();
        chk("after_reset_addr1", spm_rd_data, 32'h0);
        chk("after_reset_addr2_lost", if_spm_rd_data, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
